// File: rtl/id_stage.sv
`default_nettype none
// ============================================================================
// Module      : id_stage
// Description : MIPS-subset decode stage with register file, branch/jump
//               resolution, hazard stall and ID/EX pipeline register.
// Revision    : 1.0
// ============================================================================
module id_stage #(
   parameter int          WB_BYPASS = 1,
   parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [31:0] if_id_instruction,
   input  logic [31:0] if_id_pc_next,
   input  logic        wb_reg_write,
   input  logic [4:0]  wb_write_addr,
   input  logic [31:0] wb_write_data,
   input  logic        ex_mem_reg_write,
   input  logic        ex_mem_mem_read,
   input  logic [4:0]  ex_mem_write_addr,
   input  logic [31:0] ex_mem_alu_result,
   input  logic        stall_breakpoint,
   input  logic        continue_en,
   output logic        stall,
   output logic        flush_if,
   output logic        jump_taken,
   output logic [31:0] pc_jump,
   output logic        branch_taken,
   output logic [31:0] pc_branch,
   output logic        id_ex_reg_write,
   output logic        id_ex_mem_read,
   output logic        id_ex_mem_write,
   output logic        id_ex_mem_to_reg,
   output logic        id_ex_alu_src,
   output logic        id_ex_link,
   output logic [3:0]  id_ex_alu_op,
   output logic [31:0] id_ex_rs_data,
   output logic [31:0] id_ex_rt_data,
   output logic [31:0] id_ex_imm,
   output logic [31:0] id_ex_pc_next,
   output logic [4:0]  id_ex_rs_addr,
   output logic [4:0]  id_ex_rt_addr,
   output logic [4:0]  id_ex_write_addr,
   output logic [4:0]  id_ex_shamt
);

   localparam logic [5:0] c_OP_RTYPE = 6'h00, c_OP_J    = 6'h02, c_OP_JAL  = 6'h03,
                          c_OP_BEQ   = 6'h04, c_OP_BNE  = 6'h05, c_OP_ADDI = 6'h08,
                          c_OP_SLTI  = 6'h0A, c_OP_ANDI = 6'h0C, c_OP_ORI  = 6'h0D,
                          c_OP_LUI   = 6'h0F, c_OP_LW   = 6'h23, c_OP_SW   = 6'h2B;
   localparam logic [5:0] c_FN_SLL = 6'h00, c_FN_SRL = 6'h02, c_FN_JR  = 6'h08,
                          c_FN_ADD = 6'h20, c_FN_SUB = 6'h22, c_FN_AND = 6'h24,
                          c_FN_OR  = 6'h25, c_FN_SLT = 6'h2A;
   localparam logic [3:0] c_ALU_ADD = 4'd0, c_ALU_SUB = 4'd1, c_ALU_AND = 4'd2,
                          c_ALU_OR  = 4'd3, c_ALU_SLT = 4'd4, c_ALU_SLL = 4'd5,
                          c_ALU_SRL = 4'd6, c_ALU_LUI = 4'd7;

   logic [31:0] r_regs [32];

   logic [5:0]  w_op, w_funct;
   logic [4:0]  w_rs, w_rt, w_rd, w_shamt, w_wa;
   logic [15:0] w_imm16;
   logic [31:0] w_imm, w_rs_rd, w_rt_rd, w_fwd_rs, w_fwd_rt;
   logic        w_valid, w_rw, w_mr, w_mw, w_m2r, w_src, w_link, w_zext, w_lui;
   logic        w_use_rs, w_use_rt, w_is_j, w_is_jal, w_is_jr, w_is_beq, w_is_bne;
   logic [3:0]  w_alu;
   logic        w_load_use, w_br_stall, w_hold, w_redirect_ok;

   assign w_op    = if_id_instruction[31:26];
   assign w_rs    = if_id_instruction[25:21];
   assign w_rt    = if_id_instruction[20:16];
   assign w_rd    = if_id_instruction[15:11];
   assign w_shamt = if_id_instruction[10:6];
   assign w_funct = if_id_instruction[5:0];
   assign w_imm16 = if_id_instruction[15:0];

   always_comb begin
      w_valid = 1'b1; w_rw = 1'b0; w_mr = 1'b0; w_mw = 1'b0; w_m2r = 1'b0;
      w_src = 1'b0; w_link = 1'b0; w_zext = 1'b0; w_lui = 1'b0; w_alu = c_ALU_ADD;
      w_use_rs = 1'b0; w_use_rt = 1'b0; w_is_j = 1'b0; w_is_jal = 1'b0;
      w_is_jr = 1'b0; w_is_beq = 1'b0; w_is_bne = 1'b0; w_wa = w_rt;
      case (w_op)
         c_OP_RTYPE: begin
            w_wa = w_rd;
            case (w_funct)
               c_FN_ADD: begin w_rw = 1'b1; w_use_rs = 1'b1; w_use_rt = 1'b1; w_alu = c_ALU_ADD; end
               c_FN_SUB: begin w_rw = 1'b1; w_use_rs = 1'b1; w_use_rt = 1'b1; w_alu = c_ALU_SUB; end
               c_FN_AND: begin w_rw = 1'b1; w_use_rs = 1'b1; w_use_rt = 1'b1; w_alu = c_ALU_AND; end
               c_FN_OR:  begin w_rw = 1'b1; w_use_rs = 1'b1; w_use_rt = 1'b1; w_alu = c_ALU_OR;  end
               c_FN_SLT: begin w_rw = 1'b1; w_use_rs = 1'b1; w_use_rt = 1'b1; w_alu = c_ALU_SLT; end
               c_FN_SLL: begin w_rw = 1'b1; w_use_rt = 1'b1; w_alu = c_ALU_SLL; end
               c_FN_SRL: begin w_rw = 1'b1; w_use_rt = 1'b1; w_alu = c_ALU_SRL; end
               c_FN_JR:  begin w_is_jr = 1'b1; w_use_rs = 1'b1; end
               default:  w_valid = 1'b0;
            endcase
         end
         c_OP_J:    begin w_is_j = 1'b1; w_wa = 5'd0; end
         c_OP_JAL:  begin w_is_jal = 1'b1; w_rw = 1'b1; w_link = 1'b1; w_wa = 5'd31; end
         c_OP_BEQ:  begin w_is_beq = 1'b1; w_use_rs = 1'b1; w_use_rt = 1'b1; w_alu = c_ALU_SUB; end
         c_OP_BNE:  begin w_is_bne = 1'b1; w_use_rs = 1'b1; w_use_rt = 1'b1; w_alu = c_ALU_SUB; end
         c_OP_ADDI: begin w_rw = 1'b1; w_src = 1'b1; w_use_rs = 1'b1; end
         c_OP_SLTI: begin w_rw = 1'b1; w_src = 1'b1; w_use_rs = 1'b1; w_alu = c_ALU_SLT; end
         c_OP_ANDI: begin w_rw = 1'b1; w_src = 1'b1; w_use_rs = 1'b1; w_zext = 1'b1; w_alu = c_ALU_AND; end
         c_OP_ORI:  begin w_rw = 1'b1; w_src = 1'b1; w_use_rs = 1'b1; w_zext = 1'b1; w_alu = c_ALU_OR; end
         c_OP_LUI:  begin w_rw = 1'b1; w_src = 1'b1; w_lui = 1'b1; w_alu = c_ALU_LUI; end
         c_OP_LW:   begin w_rw = 1'b1; w_mr = 1'b1; w_m2r = 1'b1; w_src = 1'b1; w_use_rs = 1'b1; end
         c_OP_SW:   begin w_mw = 1'b1; w_src = 1'b1; w_use_rs = 1'b1; w_use_rt = 1'b1; end
         default:   w_valid = 1'b0;
      endcase
      if (if_id_instruction == NOP_INSTR) w_valid = 1'b0;
      // Bubbles must neither write, redirect nor create hazards.
      if (!w_valid) begin
         w_rw = 1'b0; w_mr = 1'b0; w_mw = 1'b0; w_m2r = 1'b0; w_src = 1'b0;
         w_link = 1'b0; w_alu = c_ALU_ADD; w_use_rs = 1'b0; w_use_rt = 1'b0;
         w_is_j = 1'b0; w_is_jal = 1'b0; w_is_jr = 1'b0; w_is_beq = 1'b0;
         w_is_bne = 1'b0; w_wa = 5'd0;
      end
      if (w_wa == 5'd0) w_rw = 1'b0;
   end

   assign w_imm = w_lui  ? {w_imm16, 16'h0000} :
                  w_zext ? {16'h0000, w_imm16} : {{16{w_imm16[15]}}, w_imm16};

   always_comb begin
      w_rs_rd = r_regs[w_rs];
      w_rt_rd = r_regs[w_rt];
      if (WB_BYPASS != 0 && wb_reg_write && wb_write_addr == w_rs) w_rs_rd = wb_write_data;
      if (WB_BYPASS != 0 && wb_reg_write && wb_write_addr == w_rt) w_rt_rd = wb_write_data;
      if (w_rs == 5'd0) w_rs_rd = 32'd0;
      if (w_rt == 5'd0) w_rt_rd = 32'd0;
   end

   assign w_fwd_rs = (ex_mem_reg_write && !ex_mem_mem_read && ex_mem_write_addr != 5'd0 &&
                      ex_mem_write_addr == w_rs) ? ex_mem_alu_result : w_rs_rd;
   assign w_fwd_rt = (ex_mem_reg_write && !ex_mem_mem_read && ex_mem_write_addr != 5'd0 &&
                      ex_mem_write_addr == w_rt) ? ex_mem_alu_result : w_rt_rd;

   assign w_load_use = id_ex_mem_read && id_ex_write_addr != 5'd0 &&
                       ((w_use_rs && w_rs == id_ex_write_addr) ||
                        (w_use_rt && w_rt == id_ex_write_addr));
   assign w_br_stall = (w_is_beq || w_is_bne || w_is_jr) &&
                       ((id_ex_reg_write && id_ex_write_addr != 5'd0 &&
                         ((w_use_rs && w_rs == id_ex_write_addr) ||
                          (w_use_rt && w_rt == id_ex_write_addr))) ||
                        (ex_mem_mem_read && ex_mem_write_addr != 5'd0 &&
                         ((w_use_rs && w_rs == ex_mem_write_addr) ||
                          (w_use_rt && w_rt == ex_mem_write_addr))));

   assign stall         = w_load_use | w_br_stall;
   assign w_hold        = stall_breakpoint & ~continue_en;
   assign w_redirect_ok = ~stall & ~w_hold;
   assign jump_taken    = w_redirect_ok & (w_is_j | w_is_jal | w_is_jr);
   assign pc_jump       = w_is_jr ? w_fwd_rs
                                  : {if_id_pc_next[31:28], if_id_instruction[25:0], 2'b00};
   assign branch_taken  = w_redirect_ok & ((w_is_beq & (w_fwd_rs == w_fwd_rt)) |
                                           (w_is_bne & (w_fwd_rs != w_fwd_rt)));
   assign pc_branch     = if_id_pc_next + {{14{w_imm16[15]}}, w_imm16, 2'b00};
   assign flush_if      = jump_taken | branch_taken;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 32; i++) r_regs[i] <= 32'd0;
      end else if (wb_reg_write && wb_write_addr != 5'd0) begin
         r_regs[wb_write_addr] <= wb_write_data;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n || stall) begin
         id_ex_reg_write <= 1'b0;  id_ex_mem_read <= 1'b0;  id_ex_mem_write <= 1'b0;
         id_ex_mem_to_reg <= 1'b0; id_ex_alu_src <= 1'b0;   id_ex_link <= 1'b0;
         id_ex_alu_op <= 4'd0;     id_ex_rs_data <= 32'd0;  id_ex_rt_data <= 32'd0;
         id_ex_imm <= 32'd0;       id_ex_pc_next <= 32'd0;  id_ex_rs_addr <= 5'd0;
         id_ex_rt_addr <= 5'd0;    id_ex_write_addr <= 5'd0; id_ex_shamt <= 5'd0;
      end else if (!w_hold) begin
         id_ex_reg_write  <= w_rw;
         id_ex_mem_read   <= w_mr;
         id_ex_mem_write  <= w_mw;
         id_ex_mem_to_reg <= w_m2r;
         id_ex_alu_src    <= w_src;
         id_ex_link       <= w_link;
         id_ex_alu_op     <= w_alu;
         id_ex_write_addr <= w_wa;
         id_ex_rs_data    <= w_valid ? w_rs_rd : 32'd0;
         id_ex_rt_data    <= w_valid ? w_rt_rd : 32'd0;
         id_ex_imm        <= w_valid ? w_imm : 32'd0;
         id_ex_pc_next    <= w_valid ? if_id_pc_next : 32'd0;
         id_ex_rs_addr    <= w_valid ? w_rs : 5'd0;
         id_ex_rt_addr    <= w_valid ? w_rt : 5'd0;
         id_ex_shamt      <= w_valid ? w_shamt : 5'd0;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_id_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_id_stage
// Description : Directed-vector scoreboard bench for id_stage.
// Revision    : 1.0
// ============================================================================
module tb_id_stage;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [31:0] if_id_instruction = 32'd0, if_id_pc_next = 32'd0;
   logic        wb_reg_write = 1'b0;
   logic [4:0]  wb_write_addr = 5'd0;
   logic [31:0] wb_write_data = 32'd0;
   logic        ex_mem_reg_write = 1'b0, ex_mem_mem_read = 1'b0;
   logic [4:0]  ex_mem_write_addr = 5'd0;
   logic [31:0] ex_mem_alu_result = 32'd0;
   logic        stall_breakpoint = 1'b0, continue_en = 1'b0;
   logic        stall, flush_if, jump_taken, branch_taken;
   logic [31:0] pc_jump, pc_branch;
   logic        id_ex_reg_write, id_ex_mem_read, id_ex_mem_write, id_ex_mem_to_reg;
   logic        id_ex_alu_src, id_ex_link;
   logic [3:0]  id_ex_alu_op;
   logic [31:0] id_ex_rs_data, id_ex_rt_data, id_ex_imm, id_ex_pc_next;
   logic [4:0]  id_ex_rs_addr, id_ex_rt_addr, id_ex_write_addr, id_ex_shamt;

   id_stage #(.WB_BYPASS(1), .NOP_INSTR(32'h0000_0000)) u_dut (
      .clk(clk), .rst_n(rst_n),
      .if_id_instruction(if_id_instruction), .if_id_pc_next(if_id_pc_next),
      .wb_reg_write(wb_reg_write), .wb_write_addr(wb_write_addr), .wb_write_data(wb_write_data),
      .ex_mem_reg_write(ex_mem_reg_write), .ex_mem_mem_read(ex_mem_mem_read),
      .ex_mem_write_addr(ex_mem_write_addr), .ex_mem_alu_result(ex_mem_alu_result),
      .stall_breakpoint(stall_breakpoint), .continue_en(continue_en),
      .stall(stall), .flush_if(flush_if), .jump_taken(jump_taken), .pc_jump(pc_jump),
      .branch_taken(branch_taken), .pc_branch(pc_branch),
      .id_ex_reg_write(id_ex_reg_write), .id_ex_mem_read(id_ex_mem_read),
      .id_ex_mem_write(id_ex_mem_write), .id_ex_mem_to_reg(id_ex_mem_to_reg),
      .id_ex_alu_src(id_ex_alu_src), .id_ex_link(id_ex_link), .id_ex_alu_op(id_ex_alu_op),
      .id_ex_rs_data(id_ex_rs_data), .id_ex_rt_data(id_ex_rt_data), .id_ex_imm(id_ex_imm),
      .id_ex_pc_next(id_ex_pc_next), .id_ex_rs_addr(id_ex_rs_addr),
      .id_ex_rt_addr(id_ex_rt_addr), .id_ex_write_addr(id_ex_write_addr),
      .id_ex_shamt(id_ex_shamt)
   );

   always #5 clk = ~clk;

   // One row = inputs for a cycle plus what the DUT must show during that cycle.
   typedef struct packed {
      logic [7:0]  id;
      logic        rst_n;
      logic [31:0] instr, pcn;
      logic        wbw;  logic [4:0] wba; logic [31:0] wbd;
      logic        emw, emr; logic [4:0] ema; logic [31:0] emd;
      logic        bp, cont;
      logic        e_stall, e_flush, e_jump, e_br;
      logic [31:0] e_pcj, e_pcb;
      logic [9:0]  e_ctl;
      logic [4:0]  e_wa, e_sh;
      logic [31:0] e_rs, e_rt, e_imm, e_pcn;
   } row_t;

   row_t r;
   row_t q[$];
   int   n_tot = 0, n_pass = 0, n_rows = 0;

   function automatic logic [31:0] fR(logic [5:0] fn, logic [4:0] rs, logic [4:0] rt,
                                      logic [4:0] rd, logic [4:0] sh);
      return {6'd0, rs, rt, rd, sh, fn};
   endfunction
   function automatic logic [31:0] fI(logic [5:0] op, logic [4:0] rs, logic [4:0] rt,
                                      logic [15:0] imm);
      return {op, rs, rt, imm};
   endfunction
   function automatic logic [9:0] c(logic rw, logic mr, logic mw, logic m2r, logic src,
                                    logic link, logic [3:0] alu);
      return {rw, mr, mw, m2r, src, link, alu};
   endfunction

   task automatic clr(logic [31:0] instr, logic [31:0] pcn);
      r = '0;
      r.rst_n = 1'b1;
      r.instr = instr;
      r.pcn   = pcn;
   endtask

   task automatic ex(logic [9:0] ctl, logic [4:0] wa, logic [31:0] rs, logic [31:0] rt,
                     logic [31:0] imm, logic [31:0] pcn, logic [4:0] sh);
      r.e_ctl = ctl; r.e_wa = wa; r.e_rs = rs; r.e_rt = rt;
      r.e_imm = imm; r.e_pcn = pcn; r.e_sh = sh;
   endtask

   task automatic wb(logic [4:0] a, logic [31:0] d);
      r.wbw = 1'b1; r.wba = a; r.wbd = d;
   endtask

   task automatic em(logic mr, logic [4:0] a, logic [31:0] d);
      r.emw = 1'b1; r.emr = mr; r.ema = a; r.emd = d;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      rst_n             = r.rst_n;
      if_id_instruction = r.instr;
      if_id_pc_next     = r.pcn;
      wb_reg_write      = r.wbw;
      wb_write_addr     = r.wba;
      wb_write_data     = r.wbd;
      ex_mem_reg_write  = r.emw;
      ex_mem_mem_read   = r.emr;
      ex_mem_write_addr = r.ema;
      ex_mem_alu_result = r.emd;
      stall_breakpoint  = r.bp;
      continue_en       = r.cont;
      r.id = 8'(n_rows);
      n_rows++;
      q.push_back(r);
   endtask

   task automatic ck(string name, logic [7:0] id, logic [31:0] act, logic [31:0] exp);
      n_tot++;
      if (act === exp) n_pass++;
      else $display("FAIL row %0d %s: got %h expected %h", id, name, act, exp);
   endtask

   initial begin : monitor
      row_t e;
      forever begin
         @(negedge clk);
         if (q.size() > 0) begin
            e = q.pop_front();
            ck("stall",   e.id, {31'd0, stall},        {31'd0, e.e_stall});
            ck("flush",   e.id, {31'd0, flush_if},     {31'd0, e.e_flush});
            ck("jump",    e.id, {31'd0, jump_taken},   {31'd0, e.e_jump});
            ck("branch",  e.id, {31'd0, branch_taken}, {31'd0, e.e_br});
            if (e.e_jump) ck("pc_jump",   e.id, pc_jump,   e.e_pcj);
            if (e.e_br)   ck("pc_branch", e.id, pc_branch, e.e_pcb);
            ck("ctl", e.id, {22'd0, id_ex_reg_write, id_ex_mem_read, id_ex_mem_write,
                             id_ex_mem_to_reg, id_ex_alu_src, id_ex_link, id_ex_alu_op},
               {22'd0, e.e_ctl});
            ck("wa",      e.id, {27'd0, id_ex_write_addr}, {27'd0, e.e_wa});
            ck("shamt",   e.id, {27'd0, id_ex_shamt},      {27'd0, e.e_sh});
            ck("rs_data", e.id, id_ex_rs_data, e.e_rs);
            ck("rt_data", e.id, id_ex_rt_data, e.e_rt);
            ck("imm",     e.id, id_ex_imm,     e.e_imm);
            ck("pc_next", e.id, id_ex_pc_next, e.e_pcn);
         end
      end
   end

   initial begin : driver
      // reset state
      clr(32'd0, 32'd0); r.rst_n = 1'b0; step();
      clr(32'd0, 32'd0); wb(5'd1, 32'd5); step();
      // WB bypass
      clr(fR(6'h20, 5'd3, 5'd3, 5'd4, 5'd0), 32'h4); wb(5'd3, 32'hDEAD_BEEF); step();
      clr(32'd0, 32'h8); ex(c(1,0,0,0,0,0,4'd0), 5'd4, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'h2020, 32'h4, 5'd0); step();
      // load-use
      clr(fI(6'h23, 5'd1, 5'd2, 16'h0), 32'hC); step();
      clr(fR(6'h20, 5'd2, 5'd2, 5'd3, 5'd0), 32'h10);
      ex(c(1,1,0,1,1,0,4'd0), 5'd2, 32'd5, 32'd0, 32'd0, 32'hC, 5'd0); r.e_stall = 1'b1; step();
      clr(fR(6'h20, 5'd2, 5'd2, 5'd3, 5'd0), 32'h10); step();
      clr(32'd0, 32'h14); ex(c(1,0,0,0,0,0,4'd0), 5'd3, 32'd0, 32'd0, 32'h1820, 32'h10, 5'd0); step();
      // branch forwarded from MEM
      clr(fI(6'h08, 5'd0, 5'd1, 16'd5), 32'h8); step();
      clr(32'd0, 32'hC); ex(c(1,0,0,0,1,0,4'd0), 5'd1, 32'd0, 32'd5, 32'd5, 32'h8, 5'd0); step();
      clr(fI(6'h04, 5'd1, 5'd1, 16'd3), 32'h10); em(1'b0, 5'd1, 32'd5);
      r.e_flush = 1'b1; r.e_br = 1'b1; r.e_pcb = 32'h1C; step();
      clr(fI(6'h05, 5'd1, 5'd0, 16'd3), 32'h20); em(1'b0, 5'd1, 32'd0);
      ex(c(0,0,0,0,0,0,4'd1), 5'd1, 32'd5, 32'd5, 32'd3, 32'h10, 5'd0); step();
      // branch source stalls (EX producer, then load in MEM)
      clr(fI(6'h08, 5'd0, 5'd7, 16'd9), 32'h24);
      ex(c(0,0,0,0,0,0,4'd1), 5'd0, 32'd5, 32'd0, 32'd3, 32'h20, 5'd0); step();
      clr(fI(6'h04, 5'd7, 5'd0, 16'd1), 32'h28);
      ex(c(1,0,0,0,1,0,4'd0), 5'd7, 32'd0, 32'd0, 32'd9, 32'h24, 5'd0); r.e_stall = 1'b1; step();
      clr(fI(6'h04, 5'd7, 5'd0, 16'd1), 32'h28); em(1'b0, 5'd7, 32'd9); step();
      clr(fI(6'h04, 5'd7, 5'd0, 16'd1), 32'h28); em(1'b1, 5'd7, 32'd9);
      ex(c(0,0,0,0,0,0,4'd1), 5'd0, 32'd0, 32'd0, 32'd1, 32'h28, 5'd0); r.e_stall = 1'b1; step();
      clr(32'd0, 32'h2C); step();
      // jal / jr
      clr({6'h03, 26'h40}, 32'h8); wb(5'd31, 32'h8);
      r.e_flush = 1'b1; r.e_jump = 1'b1; r.e_pcj = 32'h100; step();
      clr(32'd0, 32'hC); ex(c(1,0,0,0,0,1,4'd0), 5'd31, 32'd0, 32'd0, 32'h40, 32'h8, 5'd1); step();
      clr(fR(6'h08, 5'd31, 5'd0, 5'd0, 5'd0), 32'h10);
      r.e_flush = 1'b1; r.e_jump = 1'b1; r.e_pcj = 32'h8; step();
      clr(fR(6'h08, 5'd31, 5'd0, 5'd0, 5'd0), 32'h10); em(1'b0, 5'd31, 32'h200);
      ex(c(0,0,0,0,0,0,4'd0), 5'd0, 32'h8, 32'd0, 32'h8, 32'h10, 5'd0);
      r.e_flush = 1'b1; r.e_jump = 1'b1; r.e_pcj = 32'h200; step();
      // breakpoint hold
      for (int i = 0; i < 3; i++) begin
         clr(fI(6'h04, 5'd1, 5'd1, 16'd3), 32'h10);
         ex(c(0,0,0,0,0,0,4'd0), 5'd0, 32'h8, 32'd0, 32'h8, 32'h10, 5'd0);
         r.bp = 1'b1; r.cont = (i == 2);
         r.e_flush = (i == 2); r.e_br = (i == 2); r.e_pcb = 32'h1C;
         step();
      end
      clr(fI(6'h08, 5'd0, 5'd7, 16'd9), 32'h24); wb(5'd5, 32'h55);
      ex(c(0,0,0,0,0,0,4'd1), 5'd1, 32'd5, 32'd5, 32'd3, 32'h10, 5'd0); step();
      // reset mid-run, then $5 reads back 0
      clr(32'd0, 32'd0); r.rst_n = 1'b0; step();
      clr(fR(6'h20, 5'd5, 5'd5, 5'd6, 5'd0), 32'h30); step();
      clr(32'd0, 32'h34); ex(c(1,0,0,0,0,0,4'd0), 5'd6, 32'd0, 32'd0, 32'h3020, 32'h30, 5'd0); step();
      // immediate forms and shifts
      clr(fI(6'h0F, 5'd0, 5'd8, 16'h8001), 32'h40); wb(5'd1, 32'h11); step();
      clr(fI(6'h0D, 5'd1, 5'd9, 16'h8001), 32'h44); wb(5'd2, 32'h22);
      ex(c(1,0,0,0,1,0,4'd7), 5'd8, 32'd0, 32'd0, 32'h8001_0000, 32'h40, 5'd0); step();
      clr(fI(6'h2B, 5'd2, 5'd1, 16'hFFFC), 32'h48);
      ex(c(1,0,0,0,1,0,4'd3), 5'd9, 32'h11, 32'd0, 32'h0000_8001, 32'h44, 5'd0); step();
      clr(fR(6'h00, 5'd0, 5'd1, 5'd10, 5'd3), 32'h4C);
      ex(c(0,0,1,0,1,0,4'd0), 5'd1, 32'h22, 32'h11, 32'hFFFF_FFFC, 32'h48, 5'd31); step();
      clr(32'hFC00_0000, 32'h50);
      ex(c(1,0,0,0,0,0,4'd5), 5'd10, 32'd0, 32'h11, 32'h50C0, 32'h4C, 5'd3); step();
      clr(fR(6'h22, 5'd1, 5'd2, 5'd11, 5'd0), 32'h54); step();
      clr(fI(6'h0A, 5'd2, 5'd12, 16'hFFFF), 32'h58);
      ex(c(1,0,0,0,0,0,4'd1), 5'd11, 32'h11, 32'h22, 32'h5822, 32'h54, 5'd0); step();
      clr(32'd0, 32'h5C);
      ex(c(1,0,0,0,1,0,4'd4), 5'd12, 32'h22, 32'd0, 32'hFFFF_FFFF, 32'h58, 5'd31); step();

      for (int i = 0; i < 20 && q.size() > 0; i++) @(posedge clk);
      if (q.size() > 0) begin
         n_tot++;
         $display("FAIL drain: %0d rows left, expected 0", q.size());
      end
      $display("%0d/%0d checks passed", n_pass, n_tot);
      $finish;
   end

endmodule
`default_nettype wire
